// File: rtl/interboard_msg_arbiter.sv
// interboard_msg_arbiter: shares the interboard transmit channel between NUM_REQ
// game-control requesters, one pending message slot each, granted round-robin.
module interboard_msg_arbiter #(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned MSG_W         = 22,
  parameter int unsigned IDLE_MSG_TYPE = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     interboard_rst,
  input  logic [NUM_REQ-1:0]       req_en,
  input  logic [NUM_REQ*MSG_W-1:0] req_msg,
  input  logic                     inter_ready,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       req_done,
  output logic [NUM_REQ-1:0]       req_overflow,
  output logic                     ctrl_en,
  output logic                     ctrl_move_dir,
  output logic [4:0]               ctrl_block_x,
  output logic [2:0]               ctrl_block_y,
  output logic [3:0]               ctrl_msg_type,
  output logic [5:0]               ctrl_card,
  output logic [2:0]               ctrl_sel_len,
  output logic                     busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic       move_dir;
    logic [4:0] block_x;
    logic [2:0] block_y;
    logic [3:0] msg_type;
    logic [5:0] card;
    logic [2:0] sel_len;
  } msg_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_WAIT_READY
  } state_t;

  localparam msg_t IDLE_MSG = '{
    move_dir: 1'b0,
    block_x:  5'd0,
    block_y:  3'd0,
    msg_type: 4'(IDLE_MSG_TYPE),
    card:     6'd0,
    sel_len:  3'd0
  };

  state_t             state;
  state_t             state_nxt;
  logic [NUM_REQ-1:0] slot_vld;
  msg_t               slot_msg [NUM_REQ];
  msg_t               out_msg;
  logic [IDX_W-1:0]   rr;
  logic [IDX_W-1:0]   cand_idx;
  logic               cand_vld;
  logic               grant;
  logic               finish;
  logic [NUM_REQ-1:0] grant_vec;
  logic [NUM_REQ-1:0] capture;
  logic [NUM_REQ-1:0] drop;

  // Requester index base+off, wrapped into 0..NUM_REQ-1 (off <= NUM_REQ).
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                 input int unsigned      off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // First full slot searching upward from rr+1.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!cand_vld && slot_vld[wrap_idx(rr, k)]) begin
        cand_vld = 1'b1;
        cand_idx = wrap_idx(rr, k);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (inter_ready && cand_vld) begin
          grant     = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_HOLD;
      // Transmitter needs a cycle to drop inter_ready after ctrl_en.
      S_HOLD: state_nxt = S_WAIT_READY;
      S_WAIT_READY: begin
        if (inter_ready) begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    grant_vec = '0;
    if (grant) grant_vec[cand_idx] = 1'b1;
  end

  // A slot being granted this cycle can take a new message on the same edge.
  assign capture = req_en & (~slot_vld | grant_vec);
  assign drop    = req_en & slot_vld & ~grant_vec;

  // Completion pulse is suppressed when the in-flight message is abandoned by reset.
  always_comb begin
    req_done = '0;
    if (finish && !interboard_rst) req_done[rr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      rr           <= IDX_W'(NUM_REQ - 1);
      slot_vld     <= '0;
      req_overflow <= '0;
      out_msg      <= IDLE_MSG;
      ctrl_en      <= 1'b0;
      busy         <= 1'b0;
    end else if (interboard_rst) begin
      state        <= S_IDLE;
      rr           <= IDX_W'(NUM_REQ - 1);
      slot_vld     <= '0;
      req_overflow <= '0;
      out_msg      <= IDLE_MSG;
      ctrl_en      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      ctrl_en      <= (state_nxt == S_ISSUE);
      busy         <= (state_nxt != S_IDLE);
      slot_vld     <= (slot_vld & ~grant_vec) | capture;
      req_overflow <= req_overflow | drop;
      if (grant) begin
        rr      <= cand_idx;
        out_msg <= slot_msg[cand_idx];
      end else if (state_nxt == S_IDLE) begin
        out_msg <= IDLE_MSG;
      end
    end
  end

  // Slot payload storage; validity is tracked separately in slot_vld.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (capture[i]) slot_msg[i] <= req_msg[i*MSG_W +: MSG_W];
    end
  end

  assign req_ready     = ~slot_vld;
  assign ctrl_move_dir = out_msg.move_dir;
  assign ctrl_block_x  = out_msg.block_x;
  assign ctrl_block_y  = out_msg.block_y;
  assign ctrl_msg_type = out_msg.msg_type;
  assign ctrl_card     = out_msg.card;
  assign ctrl_sel_len  = out_msg.sel_len;

endmodule

// File: tb/tb_interboard_msg_arbiter.sv
// Testbench for interboard_msg_arbiter: directed scenarios plus random traffic,
// every cycle compared against a slot/queue level reference model.
module tb_interboard_msg_arbiter;

  localparam int unsigned N = 3;
  localparam int unsigned W = 22;
  localparam logic [21:0] IDLE_F    = {1'b0, 5'd0, 3'd0, 4'd15, 6'd0, 3'd0};
  localparam logic [32:0] RESET_VEC = {2'b00, IDLE_F, 3'b111, 3'b000, 3'b000};

  logic         clk = 1'b0;
  logic         rst;
  logic         interboard_rst;
  logic [N-1:0] req_en;
  logic [N*W-1:0] req_msg;
  logic         inter_ready;
  logic [N-1:0] req_ready;
  logic [N-1:0] req_done;
  logic [N-1:0] req_overflow;
  logic         ctrl_en;
  logic         ctrl_move_dir;
  logic [4:0]   ctrl_block_x;
  logic [2:0]   ctrl_block_y;
  logic [3:0]   ctrl_msg_type;
  logic [5:0]   ctrl_card;
  logic [2:0]   ctrl_sel_len;
  logic         busy;

  always #5 clk = ~clk;

  interboard_msg_arbiter #(.NUM_REQ(N), .MSG_W(W), .IDLE_MSG_TYPE(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .interboard_rst(interboard_rst),
    .req_en        (req_en),
    .req_msg       (req_msg),
    .inter_ready   (inter_ready),
    .req_ready     (req_ready),
    .req_done      (req_done),
    .req_overflow  (req_overflow),
    .ctrl_en       (ctrl_en),
    .ctrl_move_dir (ctrl_move_dir),
    .ctrl_block_x  (ctrl_block_x),
    .ctrl_block_y  (ctrl_block_y),
    .ctrl_msg_type (ctrl_msg_type),
    .ctrl_card     (ctrl_card),
    .ctrl_sel_len  (ctrl_sel_len),
    .busy          (busy)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int refire_left = 0;
  logic en_d = 1'b0;
  logic [5:0] sent [$];

  // Reference model: pending message per requester, the message on the wire and its age.
  logic [N-1:0] m_vld;
  logic [21:0]  m_msg [N];
  logic [N-1:0] m_ovf;
  logic [21:0]  m_cur;
  int           m_rr;
  int           m_gi;
  bit           m_inflight;
  int           m_age;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] mk(input logic [3:0] typ, input logic [5:0] card);
    logic [21:0] r;
    r = 22'($urandom);
    r[12:9] = typ;
    r[8:3]  = card;
    return r;
  endfunction

  function automatic logic [32:0] obs_vec();
    return {ctrl_en, busy, ctrl_move_dir, ctrl_block_x, ctrl_block_y, ctrl_msg_type,
            ctrl_card, ctrl_sel_len, req_ready, req_done, req_overflow};
  endfunction

  function automatic logic [63:0] log_pack();
    logic [63:0] v;
    v = '0;
    v[63:56] = 8'(sent.size());
    for (int i = 0; i < sent.size() && i < 8; i++) v[i*6 +: 6] = sent[i];
    return v;
  endfunction

  task automatic model_reset();
    m_vld = '0;
    m_ovf = '0;
    m_rr = N - 1;
    m_gi = 0;
    m_cur = '0;
    m_inflight = 0;
    m_age = 0;
  endtask

  function automatic logic [32:0] exp_vec();
    logic [21:0]  f;
    logic [N-1:0] done;
    f = m_inflight ? m_cur : IDLE_F;
    done = '0;
    if (m_inflight && m_age >= 2 && inter_ready && !interboard_rst) done[m_gi] = 1'b1;
    return {m_inflight && m_age == 0, m_inflight, f, ~m_vld, done, m_ovf};
  endfunction

  task automatic model_edge();
    int g;
    int idx;
    g = -1;
    if (interboard_rst) begin
      model_reset();
      return;
    end
    if (!m_inflight && inter_ready) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_rr + k) % N;
        if (g < 0 && m_vld[idx]) g = idx;
      end
    end
    if (m_inflight) begin
      if (m_age >= 2 && inter_ready) m_inflight = 0;
      else m_age++;
    end
    if (g >= 0) begin
      m_cur = m_msg[g];
      m_vld[g] = 1'b0;
      m_rr = g;
      m_gi = g;
      m_inflight = 1;
      m_age = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (req_en[i]) begin
        if (!m_vld[i]) begin
          m_vld[i] = 1'b1;
          m_msg[i] = req_msg[i*W +: W];
        end else begin
          m_ovf[i] = 1'b1;
        end
      end
    end
  endtask

  // One clock cycle: check against the model mid-cycle, then advance both.
  task automatic step();
    @(negedge clk);
    chk($sformatf("cycle%0d", cyc), 64'(obs_vec()), 64'(exp_vec()));
    if (ctrl_en) sent.push_back(ctrl_card);
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    req_en = '0;
    interboard_rst = 1'b0;
  endtask

  // Transmitter drops ready for the ctrl_en cycle and the next, acking 2 cycles later.
  task automatic run(input int n);
    logic en_n;
    for (int i = 0; i < n; i++) begin
      inter_ready = !(ctrl_en || en_d);
      #1;
      if (refire_left > 0 && req_done[0]) begin
        req_en[0] = 1'b1;
        refire_left--;
      end
      en_n = ctrl_en;
      step();
      en_d = en_n;
    end
  endtask

  initial begin
    rst = 1'b1;
    interboard_rst = 1'b0;
    inter_ready = 1'b0;
    req_en = '0;
    req_msg = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset", 64'(obs_vec()), 64'(RESET_VEC));

    // Single request with a slow transmitter
    inter_ready = 1'b1;
    req_msg[0*W +: W] = mk(4'd2, 6'd17);
    req_en = 3'b001;
    step();
    step();
    chk("s1_issue", 64'({ctrl_en, ctrl_msg_type, ctrl_card}), 64'({1'b1, 4'd2, 6'd17}));
    inter_ready = 1'b0;
    step();
    step();
    step();
    inter_ready = 1'b1;
    #1;
    chk("s1_done", 64'(req_done), 64'(3'b001));
    step();
    chk("s1_idle", 64'({busy, ctrl_msg_type, req_done}), 64'({1'b0, 4'd15, 3'b000}));

    // Simultaneous requests from a freshly cleared block, then a partial burst
    interboard_rst = 1'b1;
    step();
    sent.delete();
    for (int i = 0; i < N; i++) req_msg[i*W +: W] = mk(4'd3, 6'(i + 1));
    req_en = 3'b111;
    run(20);
    chk("s2_order", log_pack(), {8'd3, 38'd0, 6'd3, 6'd2, 6'd1});
    sent.delete();
    req_en = 3'b101;
    run(20);
    chk("s2_burst", log_pack(), {8'd2, 44'd0, 6'd3, 6'd1});

    // Fairness: requester 0 re-requests on every completion
    sent.delete();
    req_msg[0*W +: W] = mk(4'd4, 6'd10);
    req_msg[1*W +: W] = mk(4'd5, 6'd20);
    req_en = 3'b011;
    refire_left = 2;
    run(40);
    chk("s3_fair", log_pack(), {8'd4, 32'd0, 6'd10, 6'd10, 6'd20, 6'd10});

    // Overflow while the transmitter is stalled
    sent.delete();
    inter_ready = 1'b0;
    req_msg[2*W +: W] = mk(4'd6, 6'd5);
    req_en = 3'b100;
    step();
    req_msg[2*W +: W] = mk(4'd6, 6'd9);
    req_en = 3'b100;
    step();
    chk("s4_ovf", 64'(req_overflow), 64'(3'b100));
    run(20);
    chk("s4_sent", log_pack(), {8'd1, 50'd0, 6'd5});

    // New message captured in the same cycle its slot is granted
    sent.delete();
    inter_ready = 1'b0;
    req_msg[1*W +: W] = mk(4'd7, 6'd30);
    req_en = 3'b010;
    step();
    inter_ready = 1'b1;
    req_msg[1*W +: W] = mk(4'd7, 6'd31);
    req_en = 3'b010;
    step();
    chk("s5_nodrop", 64'({req_overflow, req_ready}), 64'({3'b100, 3'b101}));
    run(20);
    chk("s5_sent", log_pack(), {8'd2, 44'd0, 6'd31, 6'd30});

    // Synchronous interboard reset while waiting for the transmitter
    inter_ready = 1'b1;
    req_msg[0*W +: W] = mk(4'd8, 6'd40);
    req_en = 3'b001;
    step();
    step();
    inter_ready = 1'b0;
    req_msg[2*W +: W] = mk(4'd8, 6'd41);
    req_en = 3'b100;
    step();
    step();
    interboard_rst = 1'b1;
    inter_ready = 1'b1;
    #1;
    chk("s6_no_done", 64'(req_done), 64'(3'b000));
    step();
    chk("s6_cleared", 64'({busy, req_ready, req_overflow, req_done, ctrl_msg_type}),
        64'({1'b0, 3'b111, 3'b000, 3'b000, 4'd15}));

    // Asynchronous reset between edges while a message is issuing
    req_msg[0*W +: W] = mk(4'd9, 6'd42);
    req_en = 3'b001;
    step();
    step();
    chk("s6_issue", 64'({ctrl_en, ctrl_card}), 64'({1'b1, 6'd42}));
    #2 rst = 1'b1;
    #1;
    chk("s6_async", 64'(obs_vec()), 64'(RESET_VEC));
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    en_d = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < N; r++) begin
        req_en[r] = ($urandom_range(0, 3) == 0);
        req_msg[r*W +: W] = W'($urandom);
      end
      inter_ready = ($urandom_range(0, 9) < 7);
      interboard_rst = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/interboard_msg_arbiter.md
Name: interboard_msg_arbiter

Overview:
Shares the single interboard transmit channel between NUM_REQ game-control requesters: draw/place sender, player-move sender, turn/state sender. Each requester pulses a one-cycle message enable. The block latches each message into a per-requester pending slot and grants slots round-robin. It drives the interboard ctrl bus with a one-cycle enable, then holds the message stable until the transmitter signals ready again.

Parameters:
NUM_REQ, 3, number of requesters (2..8); requester i uses bit/field i of every packed bus.
MSG_W, 22, packed message width = move_dir(1)+block_x(5)+block_y(3)+msg_type(4)+card(6)+sel_len(3), MSB first in that order.
IDLE_MSG_TYPE, 15, msg_type driven on the output bus when no message is in flight.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
interboard_rst  in  1  synchronous clear from the other board; same effect as rst, applied on the clock edge
req_en  in  NUM_REQ  per-requester one-cycle message enable
req_msg  in  NUM_REQ*MSG_W  per-requester packed message, sampled when req_en[i]=1
inter_ready  in  1  transmitter can accept a new message
req_ready  out  NUM_REQ  slot i is empty
req_done  out  NUM_REQ  one-cycle pulse when requester i's message has been fully transmitted
req_overflow  out  NUM_REQ  sticky: req_en[i] arrived while slot i was full; the new message was dropped
ctrl_en  out  1  one-cycle send enable to interboard
ctrl_move_dir  out  1  message field
ctrl_block_x  out  5  message field
ctrl_block_y  out  3  message field
ctrl_msg_type  out  4  message field
ctrl_card  out  6  message field
ctrl_sel_len  out  3  message field
busy  out  1  a message is in flight (state != IDLE)

Behaviour:
- Reset (rst async, or interboard_rst sync): all slots empty; state IDLE; rr pointer = NUM_REQ-1, so requester 0 wins first.
  - Outputs at reset: ctrl_en=0; all ctrl fields 0 except ctrl_msg_type=IDLE_MSG_TYPE; req_ready all 1; req_done 0; req_overflow 0; busy 0.
  - A message in flight during reset is abandoned with no req_done.
- Slot capture: req_en[i]=1 with slot i empty, or slot i being granted this same cycle, loads req_msg field i into slot i.
  - req_en[i]=1 with slot i full and not granted this cycle: message dropped, req_overflow[i] set (cleared only by reset).
- States:
  - IDLE: if any slot full and inter_ready=1, grant the first full slot searching upward from rr+1 mod NUM_REQ. Copy the slot to the output register, free the slot, set rr=grant, go to ISSUE.
  - IDLE with inter_ready=0: stay; no grant.
  - ISSUE (1 cycle): ctrl_en=1, fields = granted message; go to HOLD.
  - HOLD (1 cycle): ignore inter_ready, because the transmitter needs one cycle to deassert; go to WAIT_READY.
  - WAIT_READY: fields held stable; when inter_ready=1, pulse req_done[grant] this cycle and go to IDLE.
- Latency: req_en to ctrl_en is 2 cycles minimum (capture edge, grant edge, ISSUE). Back-to-back messages have at least 1 IDLE cycle between WAIT_READY exit and the next ISSUE.
- ctrl fields are driven only in ISSUE/HOLD/WAIT_READY; in IDLE they return to the reset pattern.
- A requester may issue its next req_en in the cycle its slot is granted; req_ready[i] deasserts the cycle after capture.
- No timeout; a transmitter that never re-asserts inter_ready stalls the block, and interboard_rst is the recovery path.

Test Plan:
1. Single request: reset, inter_ready=1; pulse req_en=3'b001 with msg_type=4'd2 (DECK_DRAW-like), card=6'd17 -> ctrl_en high exactly 2 cycles later with card=17, msg_type=2. Hold inter_ready low 3 cycles then high -> req_done[0] pulses that cycle; busy falls next cycle; ctrl_msg_type returns to 15.
2. Simultaneous requests: req_en=3'b111 same cycle, distinct cards 1,2,3, transmitter acks 2 cycles after each ctrl_en -> ctrl_en order is card 1, 2, 3. Next burst 3'b101 -> order is 1 then 3 (rr continues from 2).
3. Fairness: requester 0 re-pulses immediately on each req_done while requester 1 holds one pending message -> grants alternate 0,1,0; requester 1 is never skipped.
4. Overflow: with inter_ready=0, pulse req_en[2] twice, card 5 then card 9 -> req_overflow=3'b100. When inter_ready rises, card 5 is sent; card 9 is never sent.
5. Grant/capture same cycle: requester 1 pulses a new message in the exact cycle its slot is granted -> no overflow; the second message is sent after the first completes.
6. Reset mid-flight: assert interboard_rst during WAIT_READY -> next cycle busy=0, req_ready=3'b111, no req_done. Asynchronous rst asserted between clock edges -> outputs clear before the next edge.
